// File: rtl/p19_nanov_alu_seq.sv
// Sequencer for a bit-serial 32-bit ALU: streams operands LSB first and collects the result.
// Optional feature macro: NANOV_ALU_ABORT_EN adds an abort input that cancels a running operation.
module p19_nanov_alu_seq (
    input  logic        clk,
    input  logic        rstn,
`ifdef NANOV_ALU_ABORT_EN
    input  logic        abort,
`endif
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [3:0]  alu_op,
    output logic        alu_a,
    output logic        alu_b,
    output logic        alu_cy_in,
    input  logic        alu_d,
    input  logic        alu_cy_out,
    input  logic        alu_lts
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    logic        r_state;
    logic [3:0]  r_op;
    logic [31:0] r_a_sr;
    logic [31:0] r_b_sr;
    logic [30:0] r_rsr;
    logic [31:0] r_result;
    logic [4:0]  r_cnt;
    logic        r_cy;
    logic        r_done;

    logic        w_abort;
    logic        w_slt_bit;
    logic [31:0] w_final;

`ifdef NANOV_ALU_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // Compares finish on the final carry / signed-less-than flag instead of the streamed bits.
    assign w_slt_bit = r_op[0] ? ~alu_cy_out : alu_lts;

    // Value loaded into result at the edge that ends bit 31.
    always_comb begin
        w_final = {alu_d, r_rsr};
        if (r_op[3:1] == 3'b001) begin
            w_final = {31'b0, w_slt_bit};
        end else begin
            w_final = {alu_d, r_rsr};
        end
    end

    // Operation sequencing, operand/result shifting and completion.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= ST_IDLE;
            r_op     <= 4'b0000;
            r_a_sr   <= 32'h0000_0000;
            r_b_sr   <= 32'h0000_0000;
            r_rsr    <= 31'h0000_0000;
            r_result <= 32'h0000_0000;
            r_cnt    <= 5'd0;
            r_cy     <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_RUN;
                        r_op    <= op;
                        r_a_sr  <= a;
                        r_b_sr  <= b;
                        r_cnt   <= 5'd0;
                        r_cy    <= op[1] | op[3];
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (w_abort) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_a_sr <= {1'b0, r_a_sr[31:1]};
                        r_b_sr <= {1'b0, r_b_sr[31:1]};
                        r_cy   <= alu_cy_out;
                        r_rsr  <= {alu_d, r_rsr[30:1]};
                        r_cnt  <= r_cnt + 5'd1;
                        if (r_cnt == 5'd31) begin
                            r_state  <= ST_IDLE;
                            r_done   <= 1'b1;
                            r_result <= w_final;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_state;
    assign done      = r_done;
    assign result    = r_result;
    assign alu_op    = r_state ? r_op : 4'b0000;
    assign alu_a     = r_state & r_a_sr[0];
    assign alu_b     = r_state & r_b_sr[0];
    assign alu_cy_in = r_state & r_cy;

endmodule

// File: tb/tb_p19_nanov_alu_seq.sv
// Randomized self-checking bench for p19_nanov_alu_seq with a bit-serial ALU model attached.
module tb_p19_nanov_alu_seq;

    logic        clk;
    logic        rstn;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [3:0]  alu_op;
    logic        alu_a;
    logic        alu_b;
    logic        alu_cy_in;
    logic        alu_d;
    logic        alu_cy_out;
    logic        alu_lts;
`ifdef NANOV_ALU_ABORT_EN
    logic        abort;
`endif

    int n_vec;
    int n_err;
    logic [31:0] exp_res;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0100;

    p19_nanov_alu_seq dut (
        .clk        (clk),
        .rstn       (rstn),
`ifdef NANOV_ALU_ABORT_EN
        .abort      (abort),
`endif
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_cy_in  (alu_cy_in),
        .alu_d      (alu_d),
        .alu_cy_out (alu_cy_out),
        .alu_lts    (alu_lts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-bit slice of the serial ALU: full adder (B inverted for subtract/compare) plus logic ops.
    logic m_sub;
    logic m_bb;
    logic m_sum;
    always_comb begin
        m_sub      = alu_op[3] | alu_op[1];
        m_bb       = alu_b ^ m_sub;
        m_sum      = alu_a ^ m_bb ^ alu_cy_in;
        alu_cy_out = (alu_a & m_bb) | (alu_a & alu_cy_in) | (m_bb & alu_cy_in);
        case (alu_op[2:0])
            3'b111:  alu_d = alu_a & alu_b;
            3'b110:  alu_d = alu_a | alu_b;
            3'b100:  alu_d = alu_a ^ alu_b;
            default: alu_d = m_sum;
        endcase
        alu_lts = (alu_a != alu_b) ? alu_a : m_sum;
    end

    function automatic logic [31:0] ref_alu(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        case (o)
            OP_ADD:  return x + y;
            OP_SUB:  return x - y;
            OP_SLT:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            OP_SLTU: return (x < y) ? 32'd1 : 32'd0;
            OP_AND:  return x & y;
            OP_OR:   return x | y;
            OP_XOR:  return x ^ y;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, expv, $time);
        end
    endtask

    // Called at a negedge in IDLE (or on the done cycle); returns on the done cycle.
    task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input int ign_at);
        logic [31:0] e;
        e = ref_alu(o, x, y);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        for (int k = 1; k <= 32; k++) begin
`ifdef NANOV_ALU_ABORT_EN
            abort = 1'b0;
`endif
            if (k == ign_at) begin
                start = 1'b1; op = OP_ADD; a = $urandom; b = $urandom;
            end else begin
                start = 1'b0;
            end
            check("busy_done_run", {30'b0, busy, done}, 32'h2);
            check("alu_a_bit", {31'b0, alu_a}, {31'b0, x[k-1]});
            if (k == 16) check("result_held", result, exp_res);
            @(negedge clk);
        end
        start = 1'b0;
        check("busy_done_end", {30'b0, busy, done}, 32'h1);
        check("result", result, e);
        exp_res = e;
    endtask

    logic [3:0] ops [7];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        ops = '{OP_ADD, OP_SUB, OP_SLT, OP_SLTU, OP_AND, OP_OR, OP_XOR};
        n_vec = 0; n_err = 0; exp_res = 32'h0;
        rstn = 1'b0; start = 1'b0; op = 4'b0000; a = 32'h0; b = 32'h0;
`ifdef NANOV_ALU_ABORT_EN
        abort = 1'b0;
`endif
        #3;
        check("reset_busy_done", {30'b0, busy, done}, 32'h0);
        check("reset_result", result, 32'h0);
        check("reset_alu_if", {28'b0, alu_op} | {29'b0, alu_a, alu_b, alu_cy_in}, 32'h0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        run_op(OP_ADD, 32'd5, 32'd7, 0);
        check("add_5_7", result, 32'h0000_000C);
        run_op(OP_SUB, 32'd3, 32'd5, 0);
        check("sub_3_5", result, 32'hFFFF_FFFE);
        run_op(OP_SUB, 32'h8000_0000, 32'd1, 0);
        check("sub_min_1", result, 32'h7FFF_FFFF);
        run_op(OP_SLT, 32'hFFFF_FFFF, 32'd1, 0);
        check("slt_m1_1", result, 32'h1);
        run_op(OP_SLTU, 32'hFFFF_FFFF, 32'd1, 0);
        check("sltu_max_1", result, 32'h0);
        run_op(OP_SLTU, 32'd0, 32'd0, 0);
        check("sltu_0_0", result, 32'h0);
        run_op(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 10);
        check("and_ignored_start", result, 32'hF000_F000);
        run_op(OP_XOR, 32'h1234_5678, 32'h0F0F_0F0F, 32);

        // Reset in the middle of an OR.
        start = 1'b1; op = OP_OR; a = $urandom; b = $urandom;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        rstn = 1'b0;
        #1;
        check("rst_busy_done", {30'b0, busy, done}, 32'h0);
        check("rst_result", result, 32'h0);
        check("rst_alu_if", {28'b0, alu_op} | {29'b0, alu_a, alu_b, alu_cy_in}, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        exp_res = 32'h0;
        for (int i = 0; i < 3; i++) begin
            check("post_rst_idle", {30'b0, busy, done}, 32'h0);
            @(negedge clk);
        end
        check("post_rst_result", result, 32'h0);

`ifdef NANOV_ALU_ABORT_EN
        run_op(OP_ADD, 32'h1000, 32'h0234, 0);
        start = 1'b1; op = OP_OR; a = $urandom; b = $urandom;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy_done", {30'b0, busy, done}, 32'h0);
        check("abort_result", result, 32'h0000_1234);
        @(negedge clk);
        check("abort_no_done", {30'b0, busy, done}, 32'h0);
        abort = 1'b1;
        run_op(OP_SUB, 32'd100, 32'd1, 0);
`endif

        for (int i = 0; i < 150; i++) begin
            logic [3:0]  o;
            logic [31:0] x;
            logic [31:0] y;
            o = ops[$urandom_range(0, 6)];
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 5))
                0:       y = x;
                1:       x = 32'h8000_0000;
                2:       y = 32'h7FFF_FFFF;
                default: ;
            endcase
            run_op(o, x, y, $urandom_range(0, 40));
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                check("idle_no_done", {30'b0, busy, done}, 32'h0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/p19_nanov_alu_seq.md
P19_NANOV_ALU_SEQ -- requirements
Module: p19_nanov_alu_seq

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port start  input  1  request to begin an operation; sampled only when not busy.
REQ-004 SHALL have port op  input  4  ALU opcode (ADD 0000, SUB 1000, SLT 0010, SLTU 0011, AND 0111, OR 0110, XOR 0100).
REQ-005 SHALL have port a  input  32  operand A, parallel, sampled with start.
REQ-006 SHALL have port b  input  32  operand B, parallel, sampled with start.
REQ-007 SHALL have port busy  output  1  high while bits are being streamed.
REQ-008 SHALL have port done  output  1  one-cycle pulse: result valid.
REQ-009 SHALL have port result  output  32  final value; held until the next completion.
REQ-010 SHALL have ports alu_op (out, 4), alu_a (out, 1), alu_b (out, 1), alu_cy_in (out, 1), alu_d (in, 1), alu_cy_out (in, 1), alu_lts (in, 1): connections to the bit-serial ALU.

Function
REQ-011 SHALL implement states IDLE and RUN; IDLE->RUN on start, RUN->IDLE after bit 31.
REQ-012 SHALL, on accepting start, latch op, load A and B shift registers, clear the 5-bit bit counter, and set carry flop cy = op[1] | op[3].
REQ-013 SHALL ignore start while busy, with no effect on any state.
REQ-014 SHALL accept start in IDLE, including the cycle in which done is high.
REQ-015 SHALL drive alu_a = A_sr[0], alu_b = B_sr[0], alu_cy_in = cy, alu_op = latched op in RUN (LSB first); all four SHALL be 0 in IDLE.
REQ-016 SHALL, each RUN cycle: shift A_sr and B_sr right by one, cy <= alu_cy_out, shift alu_d into the MSB of the result shift register, and increment the counter.
REQ-017 SHALL, start accepted at edge N, present bit k in cycle N+1+k, assert busy in cycles N+1..N+32, and assert done in cycle N+33 only.
REQ-018 SHALL, at the edge ending bit 31, load result = {alu_d, rsr[31:1]} for ops other than 001x.
REQ-019 SHALL, for op[3:1] = 001, load result = {31'b0, bit}, where bit = ~alu_cy_out for SLTU (op[0]=1) and alu_lts for SLT (op[0]=0).
REQ-020 SHALL leave result unchanged between completions; internal shifting SHALL NOT be visible on result.
REQ-021 SHALL treat unlisted opcodes as ordinary ops and return whatever the ALU produces.

Reset
REQ-022 SHALL, while rstn is low, asynchronously force state IDLE, busy 0, done 0, result 0, cy 0, counter 0, shift registers 0.
REQ-023 SHALL abandon an operation in progress on reset, with no done pulse, result 0, and IDLE on release.

Configuration
REQ-024 SHALL, with NANOV_ALU_ABORT_EN defined, add input port abort (1 bit); abort high in RUN SHALL return to IDLE at the next edge, with no done and result unchanged; abort SHALL take precedence over completion on bit 31; abort in IDLE SHALL have no effect and SHALL NOT block start.
REQ-025 SHALL, without NANOV_ALU_ABORT_EN, omit the abort port and always run the full 32 bits.

Verification
REQ-026 SHALL cover ADD a=5, b=7, start at edge 0 -> busy cycles 1..32, done cycle 33, result 0x0000000C.
REQ-027 SHALL cover SUB a=3, b=5 -> result 0xFFFFFFFE; SUB a=0x80000000, b=1 -> 0x7FFFFFFF.
REQ-028 SHALL cover SLT a=0xFFFFFFFF, b=1 -> 1; SLTU with the same operands -> 0; SLTU a=0, b=0 -> 0.
REQ-029 SHALL cover start pulsed at cycle 10 of an AND 0xF0F0F0F0 & 0xFF00FF00 -> ignored, result 0xF000F000 at cycle 33; a new start on the done cycle -> accepted, busy the next cycle.
REQ-030 SHALL cover rstn low at cycle 15 of an OR -> busy/done 0 immediately, result 0; with NANOV_ALU_ABORT_EN, abort at cycle 20 after a prior result 0x1234 -> no done, result stays 0x1234.
